// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice.
//   - Bit positions inside the M (memory) and WB (write-back) control bundles.
//   - State encoding for the memory-access wait-state FSM.
package mips_pkg;

    // M control bundle bit positions
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;

    // WB control bundle bit positions
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // Wait-state FSM for data-memory accesses
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data RAM.
//   clk   : write clock, rising edge
//   we    : synchronous write enable
//   addr  : word index, shared by read and write
//   wdata : store data
//   rdata : asynchronous read of mem[addr] (returns the pre-write value
//           during the cycle a write is being committed)
// Contents are not reset.
module data_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM pipeline stage plus the MEM/WB pipeline register.
// Resolves the branch select, performs the data-memory access through an
// internal RAM with LATENCY wait states, and holds upstream stages with
// stall while a multi-cycle access is in flight.
//
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   WB[1:0]               : {RegWrite, MemtoReg}
//   M[2:0]                : {Branch, MemRead, MemWrite}
//   PC                    : branch target from EX/MEM
//   zero                  : ALU zero flag
//   ALUresult             : ALU result / byte address
//   writeData             : store data
//   writeRegister         : destination register
//   PCSrc, branchTarget   : combinational branch resolution
//   stall                 : freeze EX/MEM and earlier stages
//   WB_output, readData_output, ALUresult_output, writeRegister_output,
//   align_err             : MEM/WB register outputs
//   state_dbg             : current FSM state, for observation only
//
// Build option: define MEM_ALIGN_CHECK_EN to flag and squash accesses whose
// byte address is not word aligned; otherwise the low address bits are
// ignored and align_err is constant 0.
//
// Handshake: stall is a hold request. While stall=1 the upstream stage keeps
// every input stable; inputs are consumed only on the edge where stall=0.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  WB,
    input  logic [2:0]  M,
    input  logic [31:0] PC,
    input  logic        zero,
    input  logic [31:0] ALUresult,
    input  logic [31:0] writeData,
    input  logic [4:0]  writeRegister,
    output logic        PCSrc,
    output logic [31:0] branchTarget,
    output logic        stall,
    output logic [1:0]  WB_output,
    output logic [31:0] readData_output,
    output logic [31:0] ALUresult_output,
    output logic [4:0]  writeRegister_output,
    output logic        align_err,
    output mem_state_e  state_dbg
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;

    mem_state_e    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          access;
    logic          mis;
    logic          stall_core;
    logic          complete;
    logic          we;
    logic [AW-1:0] idx;
    logic [31:0]   rdata;
    logic          unused_bits;

    // Branch resolution is independent of the memory FSM
    assign PCSrc        = M[M_BRANCH] & zero;
    assign branchTarget = PC;

    assign access = M[M_MEMREAD] | M[M_MEMWRITE];
    // High address bits are dropped, so addresses wrap modulo DEPTH
    assign idx    = ALUresult[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    assign mis         = access && (ALUresult[1:0] != 2'b00);
    assign unused_bits = ^ALUresult[31:AW+2];
`else
    assign mis         = 1'b0;
    assign unused_bits = ^{ALUresult[31:AW+2], ALUresult[1:0]};
`endif

    // Stall covers the first LATENCY cycles of an access; the cycle after
    // that (WAIT with cnt==0, or IDLE when LATENCY==0) is the completion.
    assign stall_core = ((state == IDLE) && access && (LATENCY != 0)) ||
                        ((state == WAIT) && (cnt != '0));
    assign complete   = access && !stall_core;
    // Gated by rst_n so reset drops stall immediately, without a clock
    assign stall      = rst_n && stall_core;
    // A store caught by reset never reaches the RAM
    assign we         = rst_n && complete && M[M_MEMWRITE] && !mis;
    assign state_dbg  = state;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (access && (LATENCY != 0)) begin
                    state_n = WAIT;
                    cnt_n   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    data_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_mem (
        .clk   (clk),
        .we    (we),
        .addr  (idx),
        .wdata (writeData),
        .rdata (rdata)
    );

    // MEM/WB register: bubble while stalled, otherwise capture the
    // instruction. Load data is valid only for a pure, aligned read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WB_output            <= '0;
            readData_output      <= '0;
            ALUresult_output     <= '0;
            writeRegister_output <= '0;
            align_err            <= 1'b0;
        end else if (stall_core) begin
            WB_output            <= '0;
            readData_output      <= '0;
            ALUresult_output     <= '0;
            writeRegister_output <= '0;
            align_err            <= 1'b0;
        end else begin
            WB_output[WB_REGWRITE] <= WB[WB_REGWRITE] & ~mis;
            WB_output[WB_MEMTOREG] <= WB[WB_MEMTOREG];
            readData_output        <= (M[M_MEMREAD] && !M[M_MEMWRITE] && !mis) ? rdata : '0;
            ALUresult_output       <= ALUresult;
            writeRegister_output   <= writeRegister;
            align_err              <= mis;
        end
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM pipeline stage directly downstream of the EX/MEM register.
- Consumes the EX/MEM outputs and resolves branch select.
- Performs the data-memory access through an internal word RAM with configurable wait states, and registers results into the MEM/WB pipeline register.
- Asserts stall to freeze upstream stages while a multi-cycle access is pending.

Parameters:
- DEPTH, 256: data memory size in 32-bit words; power of two.
- LATENCY, 2: wait-state cycles per load/store; 0 = single-cycle access.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- WB  in  2  [1]=RegWrite, [0]=MemtoReg
- M  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite
- PC  in  32  branch target from EX/MEM
- zero  in  1  ALU zero flag
- ALUresult  in  32  ALU result / byte address
- writeData  in  32  store data
- writeRegister  in  5  destination register
- PCSrc  out  1  Branch & zero, combinational
- branchTarget  out  32  PC passthrough, combinational
- stall  out  1  hold EX/MEM and earlier stages
- WB_output  out  2  registered WB controls
- readData_output  out  32  registered load data
- ALUresult_output  out  32  registered ALU result
- writeRegister_output  out  5  registered destination
- align_err  out  1  registered misaligned-access flag (see Optional Feature)

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is asynchronous, active-low (rst_n). While rst_n=0, all registered outputs are 0, FSM=IDLE, counter=0. RAM contents are not reset.
- Word index = ALUresult[log2(DEPTH)+1:2]. Higher bits are ignored, so addresses wrap modulo DEPTH.
- access = MemRead | MemWrite. If both are set, the op is a write and readData_output=0.
- Non-access instruction: stall=0. At the next edge MEM/WB loads WB, ALUresult, writeRegister, and readData_output=0. Latency is 1 cycle.
- FSM states IDLE and WAIT, with down-counter cnt.
- IDLE, access, LATENCY=0: complete in this cycle; stall=0.
- IDLE, access, LATENCY>0: stall=1; MEM/WB loads a bubble (all fields 0); next state WAIT with cnt=LATENCY-1.
- WAIT, cnt!=0: stall=1; bubble; cnt decrements.
- WAIT, cnt=0: stall=0; complete; next state IDLE.
- Stall therefore asserts for exactly LATENCY consecutive cycles. Total occupancy is LATENCY+1 cycles.
- Completion edge:
  - Store: write RAM exactly once.
  - Load: readData_output <= RAM[index], reading the pre-write value.
  - MEM/WB loads WB, ALUresult and writeRegister.
- Upstream holds inputs stable while stall=1. Inputs are sampled only at the completion edge.
- Back-to-back accesses: the FSM returns to IDLE at completion, and the next access starts a fresh stall sequence with no idle gap.
- PCSrc and branchTarget are purely combinational and are unaffected by the FSM.
- Reset asserted mid-access: FSM is forced to IDLE, stall drops immediately, and a pending store is abandoned (no RAM write).

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: an access with ALUresult[1:0]!=0 still runs the normal stall sequence. At completion:
  - the write is suppressed;
  - readData_output=0;
  - WB_output[1] is forced to 0;
  - align_err=1 for one cycle alongside the MEM/WB entry.
- Not defined: low address bits are ignored and align_err is tied to 0.

Decomposition:
- Shared package mips_pkg holds:
  - M bit indices (M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0);
  - WB bit indices (WB_REGWRITE=1, WB_MEMTOREG=0);
  - the FSM state enum (IDLE, WAIT).
- Sub-module data_mem: DEPTH-word RAM with synchronous write enable and asynchronous read, instantiated once.

Test Plan:
- Reset: pulse rst_n low mid-run -> all outputs 0 and stall=0 immediately, independent of clk.
- ALU op, WB=2'b10, ALUresult=0x1234, writeRegister=5 -> one cycle later WB_output=2'b10, ALUresult_output=0x1234, writeRegister_output=5, stall never high.
- LATENCY=2: store 0xDEADBEEF at 0x40, then load 0x40 -> each access gives stall high 2 cycles and bubbles; the load gives readData_output=0xDEADBEEF on its 3rd cycle.
- Branch M=3'b100 with zero=1, PC=0x80 -> PCSrc=1 and branchTarget=0x80 in the same cycle; zero=0 -> PCSrc=0.
- Wrap: with DEPTH=256, store at 0x400 then load 0x000 -> same word returned; reset during a store's stall -> RAM word unchanged.
- MEM_ALIGN_CHECK_EN: store to 0x41 -> RAM unchanged, align_err=1 for one cycle, WB_output[1]=0.
